sync_fifo: RTL

Parameterised first-word-fall-through FIFO that buffers values upstream of a `Register`/`Mux` stage, decoupling a producer from a consumer whose accept cycles do not line up. The producer writes with `push`. The head entry is always presented combinationally on `out`, so a downstream `Register` can capture it in the same cycle the consumer asserts `pop`. Overflow and underflow attempts are ignored and recorded in a sticky error flag.

---
 rtl/sync_fifo.sv | 91 +++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with a sticky overflow/underflow flag.
// The head entry is presented combinationally on `out`, so a consumer can
// capture it in the same cycle it asserts `pop`. Every output is decoded from
// registered state only, so no input reaches an output combinationally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           in,
    input  logic                       pop,
    output logic [WIDTH-1:0]           out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] STEP_P  = AW'(1);

    // The storage array has no reset: stale contents stay hidden because
    // `out` is masked whenever the FIFO is empty.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] rd_reg;
    logic [AW-1:0] wr_reg;
    logic [CW-1:0] count_reg;
    logic          err_reg;

    logic do_push;
    logic do_pop;
    logic bad_op;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == DEPTH_C);

    // A push into a full FIFO is legal only when the head leaves in the same
    // cycle; a pop from an empty FIFO is always dropped, even with a push.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign bad_op  = (push && full && !pop) || (pop && empty);

    // Tail write into the storage array.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_reg] <= in;
        end
    end

    // Pointers and occupancy; the pointers wrap on their own width and the
    // count tells full apart from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_reg    <= '0;
            wr_reg    <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) begin
                wr_reg <= wr_reg + STEP_P;
            end
            if (do_pop) begin
                rd_reg <= rd_reg + STEP_P;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + ONE_C;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - ONE_C;
            end
        end
    end

    // Sticky error flag: set by any dropped push or pop, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (bad_op) begin
            err_reg <= 1'b1;
        end
    end

    assign out   = empty ? '0 : mem[rd_reg];
    assign count = count_reg;
    assign err   = err_reg;

endmodule
